rename_regfile: RTL and testbench

RENAME_REGFILE -- requirements
Module: rename_regfile

---
 rtl/rename_regfile_if.sv | 38 +++
 rtl/rename_regfile.sv | 95 +++++++++
 tb/tb_rename_regfile.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/rename_regfile_if.sv
// Decoder read, rename, commit and flush bundle for the rename register file.
// Combinational read path; commit/rename sampled on the clock edge.
// No flow control on any of these signals.
interface rename_regfile_if #(
    parameter int REG_NUM = 32,
    parameter int DATA_W  = 32,
    parameter int ROB_W   = 4,
    parameter int NUM_RD  = 2,
    parameter int NUM_CMT = 1
);
    localparam int REG_W = $clog2(REG_NUM);

    logic                      in_rename_flag;
    logic [REG_W-1:0]          in_rename_reg;
    logic [ROB_W-1:0]          in_rename_rob;
    logic [NUM_RD*REG_W-1:0]   in_rd_reg;
    logic [NUM_RD*DATA_W-1:0]  out_rd_value;
    logic [NUM_RD*ROB_W-1:0]   out_rd_rob;
    logic [NUM_RD-1:0]         out_rd_busy;
    logic [NUM_CMT-1:0]        in_cmt_valid;
    logic [NUM_CMT*REG_W-1:0]  in_cmt_reg;
    logic [NUM_CMT*ROB_W-1:0]  in_cmt_rob;
    logic [NUM_CMT*DATA_W-1:0] in_cmt_value;
    logic                      in_rob_xbp;
    logic [REG_W:0]            out_busy_cnt;

    modport master (
        output in_rename_flag, in_rename_reg, in_rename_rob, in_rd_reg,
               in_cmt_valid, in_cmt_reg, in_cmt_rob, in_cmt_value, in_rob_xbp,
        input  out_rd_value, out_rd_rob, out_rd_busy, out_busy_cnt
    );

    modport slave (
        input  in_rename_flag, in_rename_reg, in_rename_rob, in_rd_reg,
               in_cmt_valid, in_cmt_reg, in_cmt_rob, in_cmt_value, in_rob_xbp,
        output out_rd_value, out_rd_rob, out_rd_busy, out_busy_cnt
    );
endinterface

// File: rtl/rename_regfile.sv
// Architectural register file with rename tags, busy bits and commit forwarding.
// Reads are combinational (0 cycles); writes, renames and busy count update on the edge.
// No backpressure; rdy=0 freezes all state.
module rename_regfile #(
    parameter int REG_NUM = 32,
    parameter int DATA_W  = 32,
    parameter int ROB_W   = 4,
    parameter int NUM_RD  = 2,
    parameter int NUM_CMT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    rename_regfile_if.slave   bus
);
    localparam int REG_W = $clog2(REG_NUM);

    logic [DATA_W-1:0] values_q [REG_NUM];
    logic [DATA_W-1:0] values_d [REG_NUM];
    logic [ROB_W-1:0]  rename_q [REG_NUM];
    logic [ROB_W-1:0]  rename_d [REG_NUM];
    logic [REG_NUM-1:0] busy_q, busy_d;
    logic [REG_W:0]     cnt_d, busy_cnt_q;

    always_comb begin
        values_d = values_q;
        rename_d = rename_q;
        busy_d   = busy_q;
        // Ascending port order lets the younger commit's value land last.
        for (int c = 0; c < NUM_CMT; c++) begin
            if (bus.in_cmt_valid[c] && bus.in_cmt_reg[c*REG_W +: REG_W] != '0) begin
                values_d[bus.in_cmt_reg[c*REG_W +: REG_W]] = bus.in_cmt_value[c*DATA_W +: DATA_W];
                if (rename_q[bus.in_cmt_reg[c*REG_W +: REG_W]] == bus.in_cmt_rob[c*ROB_W +: ROB_W])
                    busy_d[bus.in_cmt_reg[c*REG_W +: REG_W]] = 1'b0;
            end
        end
        if (bus.in_rob_xbp) begin
            busy_d = '0;
            for (int r = 0; r < REG_NUM; r++) rename_d[r] = '0;
        end else if (bus.in_rename_flag && bus.in_rename_reg != '0) begin
            busy_d[bus.in_rename_reg]   = 1'b1;
            rename_d[bus.in_rename_reg] = bus.in_rename_rob;
        end
        cnt_d = '0;
        for (int r = 0; r < REG_NUM; r++) cnt_d = cnt_d + {{REG_W{1'b0}}, busy_d[r]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < REG_NUM; r++) begin
                values_q[r] <= '0;
                rename_q[r] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else if (rdy) begin
            values_q   <= values_d;
            rename_q   <= rename_d;
            busy_q     <= busy_d;
            busy_cnt_q <= cnt_d;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [REG_W-1:0]  rr;
        logic [DATA_W-1:0] v;
        logic              b;

        assign rr = bus.in_rd_reg[i*REG_W +: REG_W];

        always_comb begin
            v = values_q[rr];
            b = busy_q[rr];
            if (busy_q[rr]) begin
                for (int c = 0; c < NUM_CMT; c++) begin
                    if (bus.in_cmt_valid[c] && bus.in_cmt_reg[c*REG_W +: REG_W] == rr &&
                        bus.in_cmt_rob[c*ROB_W +: ROB_W] == rename_q[rr]) begin
                        v = bus.in_cmt_value[c*DATA_W +: DATA_W];
                        b = 1'b0;
                    end
                end
            end
            if (rr == '0) begin
                v = '0;
                b = 1'b0;
            end
        end

        assign bus.out_rd_value[i*DATA_W +: DATA_W] = v;
        assign bus.out_rd_rob[i*ROB_W +: ROB_W]     = (rr == '0) ? '0 : rename_q[rr];
        assign bus.out_rd_busy[i]                   = b;
    end

    assign bus.out_busy_cnt = busy_cnt_q;
endmodule

// File: tb/tb_rename_regfile.sv
module tb_rename_regfile;
    localparam int REG_NUM = 32;
    localparam int DATA_W  = 32;
    localparam int ROB_W   = 4;
    localparam int NUM_RD  = 2;
    localparam int NUM_CMT = 2;
    localparam int REG_W   = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;

    rename_regfile_if #(.REG_NUM(REG_NUM), .DATA_W(DATA_W), .ROB_W(ROB_W),
                        .NUM_RD(NUM_RD), .NUM_CMT(NUM_CMT)) bus ();

    rename_regfile #(.REG_NUM(REG_NUM), .DATA_W(DATA_W), .ROB_W(ROB_W),
                     .NUM_RD(NUM_RD), .NUM_CMT(NUM_CMT)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit       rf;  int rr;  int rb;
        bit [1:0] cv;
        int cr0; int cb0; int cd0;
        int cr1; int cb1; int cd1;
        bit       xbp;
        int rd0; int rd1;
        int ev0; int erob0; bit eb0;
        int ev1; bit eb1;
        int ecnt;
    } vec_t;

    vec_t tbl[$];

    task automatic drive(input bit rf, input int rr, input int rb, input bit [1:0] cv,
                         input int cr0, input int cb0, input int cd0,
                         input int cr1, input int cb1, input int cd1,
                         input bit xbp, input int rd0, input int rd1);
        bus.in_rename_flag = rf;
        bus.in_rename_reg  = REG_W'(rr);
        bus.in_rename_rob  = ROB_W'(rb);
        bus.in_cmt_valid   = cv;
        bus.in_cmt_reg     = {REG_W'(cr1), REG_W'(cr0)};
        bus.in_cmt_rob     = {ROB_W'(cb1), ROB_W'(cb0)};
        bus.in_cmt_value   = {DATA_W'(cd1), DATA_W'(cd0)};
        bus.in_rob_xbp     = xbp;
        bus.in_rd_reg      = {REG_W'(rd1), REG_W'(rd0)};
    endtask

    task automatic idle();
        drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reference model: per-register arrays updated from the rules directly.
    int m_val [REG_NUM];
    int m_tag [REG_NUM];
    bit m_busy[REG_NUM];

    task automatic model_reset();
        for (int r = 0; r < REG_NUM; r++) begin
            m_val[r] = 0; m_tag[r] = 0; m_busy[r] = 0;
        end
    endtask

    task automatic model_read(input int r, input bit [1:0] cv, input int cr[2], input int cb[2],
                              input int cd[2], output int v, output int t, output bit b);
        v = m_val[r]; t = m_tag[r]; b = m_busy[r];
        if (r == 0) begin v = 0; t = 0; b = 0; end
        else if (m_busy[r]) begin
            for (int c = 0; c < 2; c++)
                if (cv[c] && cr[c] == r && cb[c] == m_tag[r]) begin v = cd[c]; b = 0; end
        end
    endtask

    task automatic model_step(input bit en, input bit rf, input int rr, input int rb,
                              input bit [1:0] cv, input int cr[2], input int cb[2],
                              input int cd[2], input bit xbp);
        bit clr[REG_NUM];
        if (!en) return;
        for (int r = 0; r < REG_NUM; r++) clr[r] = 0;
        for (int c = 0; c < 2; c++)
            if (cv[c] && cr[c] != 0) begin
                m_val[cr[c]] = cd[c];
                if (m_tag[cr[c]] == cb[c]) clr[cr[c]] = 1;
            end
        for (int r = 0; r < REG_NUM; r++) if (clr[r]) m_busy[r] = 0;
        if (xbp) begin
            for (int r = 0; r < REG_NUM; r++) begin m_busy[r] = 0; m_tag[r] = 0; end
        end else if (rf && rr != 0) begin
            m_busy[rr] = 1; m_tag[rr] = rb;
        end
    endtask

    function automatic int model_cnt();
        int n = 0;
        for (int r = 0; r < REG_NUM; r++) n += m_busy[r];
        return n;
    endfunction

    initial begin
        //          rf rr rb cv     cr0 cb0 cd0      cr1 cb1 cd1   xbp rd0 rd1  ev0      erob0 eb0 ev1    eb1 ecnt
        tbl.push_back('{1, 3, 7, 2'b00, 0, 0, 0,       0, 0, 0,    0,  3,  0,   0,       0,    0,  0,     0,  1});
        tbl.push_back('{0, 0, 0, 2'b01, 3, 7, 'hDEAD,  0, 0, 0,    0,  3,  3,   'hDEAD,  7,    0,  'hDEAD,0,  0});
        tbl.push_back('{0, 0, 0, 2'b00, 0, 0, 0,       0, 0, 0,    0,  3,  0,   'hDEAD,  7,    0,  0,     0,  0});
        tbl.push_back('{1, 3, 7, 2'b00, 0, 0, 0,       0, 0, 0,    0,  3,  0,   'hDEAD,  7,    0,  0,     0,  1});
        tbl.push_back('{1, 3, 9, 2'b00, 0, 0, 0,       0, 0, 0,    0,  3,  0,   'hDEAD,  7,    1,  0,     0,  1});
        tbl.push_back('{0, 0, 0, 2'b01, 3, 7, 'h11,    0, 0, 0,    0,  3,  0,   'hDEAD,  9,    1,  0,     0,  1});
        tbl.push_back('{0, 0, 0, 2'b00, 0, 0, 0,       0, 0, 0,    0,  3,  0,   'h11,    9,    1,  0,     0,  1});
        tbl.push_back('{1, 4, 1, 2'b00, 0, 0, 0,       0, 0, 0,    0,  4,  0,   0,       0,    0,  0,     0,  2});
        tbl.push_back('{1, 4, 2, 2'b01, 4, 1, 'h44,    0, 0, 0,    0,  4,  3,   'h44,    1,    0,  'h11,  1,  2});
        tbl.push_back('{0, 0, 0, 2'b00, 0, 0, 0,       0, 0, 0,    0,  4,  0,   'h44,    2,    1,  0,     0,  2});
        tbl.push_back('{1, 1, 3, 2'b00, 0, 0, 0,       0, 0, 0,    0,  1,  0,   0,       0,    0,  0,     0,  3});
        tbl.push_back('{1, 2, 4, 2'b00, 0, 0, 0,       0, 0, 0,    0,  2,  1,   0,       0,    0,  0,     1,  4});
        tbl.push_back('{1, 6, 5, 2'b00, 0, 0, 0,       0, 0, 0,    0,  6,  2,   0,       0,    0,  0,     1,  5});
        tbl.push_back('{1, 7, 6, 2'b01, 6, 5, 'h55,    0, 0, 0,    1,  6,  1,   'h55,    5,    0,  0,     1,  0});
        tbl.push_back('{0, 0, 0, 2'b00, 0, 0, 0,       0, 0, 0,    0,  6,  7,   'h55,    0,    0,  0,     0,  0});
        tbl.push_back('{0, 0, 0, 2'b11, 8, 0, 'hA,     8, 0, 'hB,  0,  8,  0,   0,       0,    0,  0,     0,  0});
        tbl.push_back('{1, 0, 3, 2'b01, 0, 0, 'h99,    0, 0, 0,    0,  8,  0,   'hB,     0,    0,  0,     0,  0});
        tbl.push_back('{0, 0, 0, 2'b00, 0, 0, 0,       0, 0, 0,    0,  0,  8,   0,       0,    0,  'hB,   0,  0});
        tbl.push_back('{1, 9, 2, 2'b00, 0, 0, 0,       0, 0, 0,    0,  9,  0,   0,       0,    0,  0,     0,  1});
        tbl.push_back('{0, 0, 0, 2'b11, 9, 2, 'h91,    9, 2, 'h92, 0,  9,  9,   'h92,    2,    0,  'h92,  0,  0});
        tbl.push_back('{0, 0, 0, 2'b00, 0, 0, 0,       0, 0, 0,    0,  9,  0,   'h92,    2,    0,  0,     0,  0});

        idle();
        rst = 1'b0;
        #1;
        chk("reset cnt", 64'(bus.out_busy_cnt), 64'd0);
        chk("reset busy", 64'(bus.out_rd_busy), 64'd0);
        #12 rst = 1'b1;

        foreach (tbl[k]) begin
            @(negedge clk);
            drive(tbl[k].rf, tbl[k].rr, tbl[k].rb, tbl[k].cv, tbl[k].cr0, tbl[k].cb0, tbl[k].cd0,
                  tbl[k].cr1, tbl[k].cb1, tbl[k].cd1, tbl[k].xbp, tbl[k].rd0, tbl[k].rd1);
            #1;
            chk($sformatf("row%0d val0", k), 64'(bus.out_rd_value[31:0]), 64'(tbl[k].ev0));
            chk($sformatf("row%0d rob0", k), 64'(bus.out_rd_rob[3:0]), 64'(tbl[k].erob0));
            chk($sformatf("row%0d busy0", k), 64'(bus.out_rd_busy[0]), 64'(tbl[k].eb0));
            chk($sformatf("row%0d val1", k), 64'(bus.out_rd_value[63:32]), 64'(tbl[k].ev1));
            chk($sformatf("row%0d busy1", k), 64'(bus.out_rd_busy[1]), 64'(tbl[k].eb1));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d cnt", k), 64'(bus.out_busy_cnt), 64'(tbl[k].ecnt));
        end

        // rdy=0 freezes state
        @(negedge clk);
        rdy = 1'b0;
        drive(1, 5, 1, 2'b01, 9, 2, 'h77, 0, 0, 0, 0, 5, 9);
        @(posedge clk); #1;
        chk("frozen cnt", 64'(bus.out_busy_cnt), 64'd0);
        chk("frozen busy5", 64'(bus.out_rd_busy[0]), 64'd0);
        @(negedge clk);
        idle();
        bus.in_rd_reg = {5'd9, 5'd5};
        #1;
        chk("frozen val9", 64'(bus.out_rd_value[63:32]), 64'h92);

        // async reset mid-run with r5 busy
        rdy = 1'b1;
        drive(1, 5, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 5, 9);
        @(posedge clk); #1;
        chk("pre-rst cnt", 64'(bus.out_busy_cnt), 64'd1);
        chk("pre-rst busy5", 64'(bus.out_rd_busy[0]), 64'd1);
        @(negedge clk);
        idle();
        bus.in_rd_reg = {5'd9, 5'd5};
        #1 rst = 1'b0;
        #1;
        chk("rst busy5", 64'(bus.out_rd_busy[0]), 64'd0);
        chk("rst val9", 64'(bus.out_rd_value[63:32]), 64'd0);
        chk("rst cnt", 64'(bus.out_busy_cnt), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();

        // randomized phase against the reference model
        for (int n = 0; n < 1500; n++) begin
            bit rf, xbp, en;
            bit [1:0] cv;
            int rr, rb, cr[2], cb[2], cd[2], rd[2], ev, et;
            bit eb;
            @(negedge clk);
            en  = ($urandom_range(0, 9) != 0);
            rf  = $urandom_range(0, 1);
            rr  = $urandom_range(0, 7);
            rb  = $urandom_range(0, 3);
            cv  = 2'($urandom_range(0, 3));
            xbp = ($urandom_range(0, 24) == 0);
            for (int c = 0; c < 2; c++) begin
                cr[c] = $urandom_range(0, 7);
                cb[c] = $urandom_range(0, 3);
                cd[c] = int'($urandom);
                rd[c] = $urandom_range(0, 7);
            end
            rdy = en;
            drive(rf, rr, rb, cv, cr[0], cb[0], cd[0], cr[1], cb[1], cd[1], xbp, rd[0], rd[1]);
            #1;
            for (int p = 0; p < 2; p++) begin
                model_read(rd[p], cv, cr, cb, cd, ev, et, eb);
                chk($sformatf("rnd%0d p%0d val", n, p), 64'(bus.out_rd_value[p*32 +: 32]), 64'(unsigned'(ev)));
                chk($sformatf("rnd%0d p%0d rob", n, p), 64'(bus.out_rd_rob[p*4 +: 4]), 64'(et));
                chk($sformatf("rnd%0d p%0d busy", n, p), 64'(bus.out_rd_busy[p]), 64'(eb));
            end
            @(posedge clk);
            model_step(en, rf, rr, rb, cv, cr, cb, cd, xbp);
            #1;
            chk($sformatf("rnd%0d cnt", n), 64'(bus.out_busy_cnt), 64'(model_cnt()));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
